// File: rtl/ir_receiver.sv
// IR remote frame decoder: recovers the carrier envelope, times bursts and gaps in
// units, and decodes START / SELECT / 4 command bits into COMMAND with strobes.
module ir_receiver #(
   parameter int CLK_PER_UNIT   = 2500,
   parameter int ENV_HOLD       = 3000,
   parameter int START_UNITS    = 191,
   parameter int SELECT_UNITS   = 47,
   parameter int ASSERT_UNITS   = 47,
   parameter int DEASSERT_UNITS = 22,
   parameter int TOL_UNITS      = 4,
   parameter int GAP_MAX_UNITS  = 40
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       IR_IN,
   output logic [3:0] COMMAND,
   output logic       COMMAND_VALID,
   output logic       FRAME_ERR,
   output logic       BUSY
);

   localparam int PRESC_W = $clog2(CLK_PER_UNIT + 1);
   localparam int HOLD_W  = $clog2(ENV_HOLD + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SEL,
      BITS
   } state_t;

   typedef enum logic [1:0] {
      CLS_INVALID,
      CLS_START,
      CLS_LONG,
      CLS_SHORT
   } burst_class_t;

   logic               sync_ff1;
   logic               sync_ff2;
   logic               sync_prev;
   logic               ir_rise;

   logic               env;
   logic               env_d;
   logic               env_edge;
   logic               env_fall;
   logic [HOLD_W-1:0]  hold_cnt;

   logic [PRESC_W-1:0] presc_cnt;
   logic [7:0]         unit_cnt;

   burst_class_t       burst_class;
   logic               is_select;
   logic               gap_timeout;

   state_t             state;
   state_t             state_next;

   logic [1:0]         bit_cnt;
   logic [2:0]         shift_reg;
   logic               shift_en;
   logic               shift_bit;
   logic               bits_clear;
   logic               frame_done;
   logic               frame_abort;

   function automatic logic in_window(input logic [7:0] u, input int nominal);
      return (int'(u) >= nominal - TOL_UNITS) && (int'(u) <= nominal + TOL_UNITS);
   endfunction

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync_ff1  <= 1'b0;
         sync_ff2  <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync_ff1  <= IR_IN;
         sync_ff2  <= sync_ff1;
         sync_prev <= sync_ff2;
      end
   end

   assign ir_rise = sync_ff2 & ~sync_prev;

   // Envelope stays high for ENV_HOLD cycles past the last carrier edge, bridging carrier gaps.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         env      <= 1'b0;
         env_d    <= 1'b0;
         hold_cnt <= '0;
      end else begin
         env_d <= env;
         if (ir_rise) begin
            env      <= 1'b1;
            hold_cnt <= HOLD_W'(ENV_HOLD);
         end else if (env) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) begin
               env <= 1'b0;
            end
         end
      end
   end

   assign env_edge = env ^ env_d;
   assign env_fall = env_d & ~env;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         presc_cnt <= '0;
         unit_cnt  <= '0;
      end else if (env_edge) begin
         presc_cnt <= '0;
         unit_cnt  <= '0;
      end else if (presc_cnt == PRESC_W'(CLK_PER_UNIT - 1)) begin
         presc_cnt <= '0;
         if (unit_cnt != 8'hFF) begin
            unit_cnt <= unit_cnt + 8'd1;
         end
      end else begin
         presc_cnt <= presc_cnt + PRESC_W'(1);
      end
   end

   // On the fall cycle unit_cnt still holds the length of the burst that just ended.
   always_comb begin
      burst_class = CLS_INVALID;
      if (in_window(unit_cnt, START_UNITS)) begin
         burst_class = CLS_START;
      end else if (in_window(unit_cnt, ASSERT_UNITS)) begin
         burst_class = CLS_LONG;
      end else if (in_window(unit_cnt, DEASSERT_UNITS)) begin
         burst_class = CLS_SHORT;
      end
   end

   assign is_select   = in_window(unit_cnt, SELECT_UNITS);
   assign gap_timeout = (state != IDLE) && !env && !env_d &&
                        (unit_cnt > 8'(GAP_MAX_UNITS));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (env_fall) begin
         case (state)
            IDLE: begin
               if (burst_class == CLS_START) begin
                  state_next = WAIT_SEL;
               end
            end
            WAIT_SEL: begin
               if (is_select) begin
                  state_next = BITS;
               end else if (burst_class != CLS_START) begin
                  state_next = IDLE;
               end
            end
            BITS: begin
               case (burst_class)
                  CLS_START: state_next = WAIT_SEL;
                  CLS_LONG,
                  CLS_SHORT: begin
                     if (bit_cnt == 2'd3) begin
                        state_next = IDLE;
                     end
                  end
                  default:   state_next = IDLE;
               endcase
            end
            default: state_next = IDLE;
         endcase
      end else if (gap_timeout) begin
         state_next = IDLE;
      end
   end

   // A different-car SELECT leaves WAIT_SEL silently; only INVALID bursts abort with an error.
   always_comb begin
      shift_en    = 1'b0;
      shift_bit   = 1'b0;
      bits_clear  = 1'b0;
      frame_done  = 1'b0;
      frame_abort = 1'b0;
      BUSY        = (state != IDLE);
      if (env_fall) begin
         case (state)
            WAIT_SEL: begin
               if (is_select) begin
                  bits_clear = 1'b1;
               end else if (burst_class == CLS_INVALID) begin
                  frame_abort = 1'b1;
               end
            end
            BITS: begin
               if ((burst_class == CLS_LONG) || (burst_class == CLS_SHORT)) begin
                  shift_en   = 1'b1;
                  shift_bit  = (burst_class == CLS_LONG);
                  frame_done = (bit_cnt == 2'd3);
               end else if (burst_class == CLS_INVALID) begin
                  frame_abort = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end else if (gap_timeout) begin
         frame_abort = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         shift_reg     <= '0;
         bit_cnt       <= '0;
         COMMAND       <= '0;
         COMMAND_VALID <= 1'b0;
         FRAME_ERR     <= 1'b0;
      end else begin
         COMMAND_VALID <= frame_done;
         FRAME_ERR     <= frame_abort;
         if (bits_clear) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else if (shift_en) begin
            shift_reg <= {shift_reg[1:0], shift_bit};
            bit_cnt   <= bit_cnt + 2'd1;
         end
         if (frame_done) begin
            COMMAND <= {shift_reg, shift_bit};
         end
      end
   end

endmodule

// File: tb/tb_ir_receiver.sv
// Directed bench for ir_receiver with a shortened unit (4 cycles) so whole frames simulate quickly.
module tb_ir_receiver;

   localparam int CPU  = 4;
   localparam int HOLD = 5;
   localparam int GAP  = 10;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       IR_IN;
   logic [3:0] COMMAND;
   logic       COMMAND_VALID;
   logic       FRAME_ERR;
   logic       BUSY;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int valid_cyc = 0;
   int err_cyc = 0;
   int last_rise_cyc = 0;
   int v0;
   int e0;
   int lat;

   ir_receiver #(
      .CLK_PER_UNIT(CPU),
      .ENV_HOLD(HOLD)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .IR_IN(IR_IN),
      .COMMAND(COMMAND),
      .COMMAND_VALID(COMMAND_VALID),
      .FRAME_ERR(FRAME_ERR),
      .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc = cyc + 1;

   always @(negedge CLK) begin
      if (COMMAND_VALID) begin
         valid_cnt = valid_cnt + 1;
         valid_cyc = cyc;
      end
      if (FRAME_ERR) begin
         err_cnt = err_cnt + 1;
         err_cyc = cyc;
      end
      if (COMMAND_VALID && FRAME_ERR) both_cnt = both_cnt + 1;
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks = checks + 1;
      if (actual != expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // One burst of 'units' carrier pulses (period CPU) followed by 'gap_units' of silence.
   task automatic applyStimulus(input int units, input int gap_units);
      @(negedge CLK);
      repeat (units) begin
         IR_IN = 1'b1;
         last_rise_cyc = cyc;
         repeat (2) @(negedge CLK);
         IR_IN = 1'b0;
         repeat (2) @(negedge CLK);
      end
      repeat (gap_units * CPU) @(negedge CLK);
   endtask

   task automatic send_frame(input logic [3:0] cmd);
      applyStimulus(191, GAP);
      applyStimulus(47, GAP);
      for (int i = 3; i >= 0; i--) applyStimulus(cmd[i] ? 47 : 22, GAP);
   endtask

   task automatic settle();
      @(posedge CLK);
      #1;
   endtask

   task automatic snapshot();
      settle();
      v0 = valid_cnt;
      e0 = err_cnt;
   endtask

   initial begin
      RESET = 1'b0;
      IR_IN = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      checkOutput("reset_command", int'(COMMAND), 0);
      checkOutput("reset_valid", int'(COMMAND_VALID), 0);
      checkOutput("reset_err", int'(FRAME_ERR), 0);
      checkOutput("reset_busy", int'(BUSY), 0);
      RESET = 1'b1;

      // Frame 4'hA at nominal timing
      snapshot();
      applyStimulus(191, GAP);
      settle();
      checkOutput("busy_after_start", int'(BUSY), 1);
      applyStimulus(47, GAP);
      applyStimulus(47, GAP);
      applyStimulus(22, GAP);
      applyStimulus(47, GAP);
      settle();
      checkOutput("busy_after_bit3", int'(BUSY), 1);
      applyStimulus(22, GAP);
      settle();
      checkOutput("a_valid_pulses", valid_cnt - v0, 1);
      checkOutput("a_err_pulses", err_cnt - e0, 0);
      checkOutput("a_command", int'(COMMAND), 4'hA);
      checkOutput("a_busy_idle", int'(BUSY), 0);
      lat = valid_cyc - last_rise_cyc;
      checkOutput("a_latency_in_range", int'((lat >= HOLD + 2) && (lat <= HOLD + 4)), 1);

      // Back-to-back 4'h0 then 4'hF
      snapshot();
      send_frame(4'h0);
      settle();
      checkOutput("zero_valid_pulses", valid_cnt - v0, 1);
      checkOutput("zero_command", int'(COMMAND), 4'h0);
      send_frame(4'hF);
      settle();
      checkOutput("f_valid_pulses", valid_cnt - v0, 2);
      checkOutput("f_command", int'(COMMAND), 4'hF);
      checkOutput("zf_err_pulses", err_cnt - e0, 0);

      // Tolerance edges: 43/51 are ones, 18/26 are zeros -> 4'b1010
      snapshot();
      applyStimulus(191, GAP);
      applyStimulus(47, GAP);
      applyStimulus(43, GAP);
      applyStimulus(26, GAP);
      applyStimulus(51, GAP);
      applyStimulus(18, GAP);
      settle();
      checkOutput("tol_valid_pulses", valid_cnt - v0, 1);
      checkOutput("tol_command", int'(COMMAND), 4'hA);

      // 42 units inside BITS is out of every window
      snapshot();
      applyStimulus(191, GAP);
      applyStimulus(47, GAP);
      applyStimulus(47, GAP);
      applyStimulus(42, GAP);
      settle();
      checkOutput("b42_err_pulses", err_cnt - e0, 1);
      checkOutput("b42_valid_pulses", valid_cnt - v0, 0);
      checkOutput("b42_command_kept", int'(COMMAND), 4'hA);
      checkOutput("b42_busy", int'(BUSY), 0);

      snapshot();
      applyStimulus(191, GAP);
      applyStimulus(47, GAP);
      applyStimulus(52, GAP);
      settle();
      checkOutput("b52_err_pulses", err_cnt - e0, 1);
      checkOutput("b52_valid_pulses", valid_cnt - v0, 0);
      checkOutput("b52_command_kept", int'(COMMAND), 4'hA);

      // Frame abandoned after 2 bits: gap timeout
      snapshot();
      applyStimulus(191, GAP);
      applyStimulus(47, GAP);
      applyStimulus(47, GAP);
      applyStimulus(22, 60);
      settle();
      checkOutput("stop_err_pulses", err_cnt - e0, 1);
      checkOutput("stop_valid_pulses", valid_cnt - v0, 0);
      checkOutput("stop_busy", int'(BUSY), 0);
      lat = err_cyc - last_rise_cyc;
      checkOutput("stop_err_timing", int'((lat >= HOLD + 2 + 41 * CPU) && (lat <= HOLD + 4 + 42 * CPU)), 1);

      // START after bit 2 resynchronises, then 4'b0110
      snapshot();
      applyStimulus(191, GAP);
      applyStimulus(47, GAP);
      applyStimulus(47, GAP);
      applyStimulus(22, GAP);
      send_frame(4'h6);
      settle();
      checkOutput("resync_valid_pulses", valid_cnt - v0, 1);
      checkOutput("resync_err_pulses", err_cnt - e0, 0);
      checkOutput("resync_command", int'(COMMAND), 4'h6);

      // Reset asserted in the middle of bit 3
      applyStimulus(191, GAP);
      applyStimulus(47, GAP);
      applyStimulus(47, GAP);
      applyStimulus(22, GAP);
      applyStimulus(20, 0);
      RESET = 1'b0;
      settle();
      checkOutput("midreset_command", int'(COMMAND), 0);
      checkOutput("midreset_busy", int'(BUSY), 0);
      checkOutput("midreset_valid", int'(COMMAND_VALID), 0);
      snapshot();
      RESET = 1'b1;
      applyStimulus(0, 20);
      send_frame(4'h9);
      settle();
      checkOutput("after_reset_valid_pulses", valid_cnt - v0, 1);
      checkOutput("after_reset_err_pulses", err_cnt - e0, 0);
      checkOutput("after_reset_command", int'(COMMAND), 4'h9);

      // SELECT of 22 units is another car's frame: dropped silently
      snapshot();
      applyStimulus(191, GAP);
      applyStimulus(22, 50);
      settle();
      checkOutput("othercar_valid_pulses", valid_cnt - v0, 0);
      checkOutput("othercar_err_pulses", err_cnt - e0, 0);
      checkOutput("othercar_busy", int'(BUSY), 0);
      checkOutput("othercar_command_kept", int'(COMMAND), 4'h9);

      checkOutput("strobes_exclusive", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
